// File: rtl/axi_pkg.sv
// Shared AXI constants, default IDs and the line-master FSM state encoding.
package axi_pkg;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [3:0] DEF_RD_ID   = 4'd0;
   localparam logic [3:0] DEF_WR_ID   = 4'd1;

   // AXI size code for a full 64-bit beat
   localparam logic [2:0] SIZE_64     = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_WR   = 3'd3,
      ST_B    = 3'd4,
      ST_RESP = 3'd5
   } axi_state_e;

endpackage

// File: rtl/axi_beat_buf.sv
// Line-sized beat buffer: whole-line load, per-beat store at the counter,
// beat select at the counter, and a beat counter that saturates at LINE_BEATS
// so surplus read beats are dropped but still recognisable as surplus.
module axi_beat_buf #(
   parameter  int LINE_BEATS = 4,
   localparam int LW         = LINE_BEATS * 64,
   localparam int CW         = $clog2(LINE_BEATS) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic [LW-1:0] load_data,
   input  logic          store_en,
   input  logic [63:0]   store_data,
   input  logic          adv_en,
   output logic [CW-1:0] cnt,
   output logic [63:0]   beat_sel,
   output logic [LW-1:0] line_data
);

   localparam logic [CW-1:0] CNT_MAX = CW'(LINE_BEATS);

   logic [LW-1:0] buf_q, buf_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-2:0] idx;

   // Next buffer contents and counter: load wins, otherwise store/advance at the counter
   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      idx   = cnt_q[CW-2:0];
      if (load_en) begin
         buf_d = load_data;
         cnt_d = '0;
      end else begin
         if (store_en && (cnt_q != CNT_MAX)) begin
            for (int i = 0; i < LINE_BEATS; i++) begin
               if (idx == i[CW-2:0]) buf_d[i*64 +: 64] = store_data;
            end
         end
         if ((store_en || adv_en) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
      end
   end

   // Beat currently addressed by the counter
   always_comb begin
      beat_sel = '0;
      for (int i = 0; i < LINE_BEATS; i++) begin
         if (idx == i[CW-2:0]) beat_sel = buf_q[i*64 +: 64];
      end
   end

   // Buffer and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

   assign cnt       = cnt_q;
   assign line_data = buf_q;

endmodule

// File: rtl/axi_line_master.sv
// AXI3 master issuing one cache-line (or single-beat) read or write at a time.
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
// this master never makes a valid wait for its ready, and holds address fields
// stable while a valid is up.
module axi_line_master
   import axi_pkg::*;
#(
   parameter  int         LINE_BEATS = 4,
   parameter  logic [3:0] RD_ID      = DEF_RD_ID,
   parameter  logic [3:0] WR_ID      = DEF_WR_ID,
   localparam int         LW         = LINE_BEATS * 64
) (
   input  logic          aclk,
   input  logic          areset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [31:0]   req_addr,
   input  logic          req_single,
   input  logic [2:0]    req_size,
   input  logic [7:0]    req_wstrb,
   input  logic [LW-1:0] req_wdata,
   output logic          resp_valid,
   output logic          resp_err,
   output logic [LW-1:0] resp_rdata,
   output logic [31:0]   araddr,
   output logic [3:0]    arid,
   output logic [7:0]    arlen,
   output logic [2:0]    arsize,
   output logic [1:0]    arburst,
   output logic [1:0]    arlock,
   output logic [3:0]    arcache,
   output logic [2:0]    arprot,
   output logic          arvalid,
   input  logic          arready,
   input  logic [3:0]    rid,
   input  logic [63:0]   rdata,
   input  logic [1:0]    rresp,
   input  logic          rlast,
   input  logic          rvalid,
   output logic          rready,
   output logic [3:0]    awid,
   output logic [31:0]   awaddr,
   output logic [7:0]    awlen,
   output logic [2:0]    awsize,
   output logic [1:0]    awburst,
   output logic [1:0]    awlock,
   output logic [3:0]    awcache,
   output logic [2:0]    awprot,
   output logic          awvalid,
   input  logic          awready,
   output logic [3:0]    wid,
   output logic [63:0]   wdata,
   output logic [7:0]    wstrb,
   output logic          wlast,
   output logic          wvalid,
   input  logic          wready,
   input  logic [3:0]    bid,
   input  logic [1:0]    bresp,
   input  logic          bvalid,
   output logic          bready,
   output axi_state_e    dbg_state
);

   localparam int         CW        = $clog2(LINE_BEATS) + 1;
   localparam logic [31:0] LINE_MASK = ~(32'(LINE_BEATS * 8) - 32'd1);
   localparam logic [7:0]  LINE_LEN  = 8'(LINE_BEATS - 1);

   axi_state_e    state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [7:0]    len_q, len_d;
   logic [2:0]    size_q, size_d;
   logic [7:0]    wstrb_q, wstrb_d;
   logic          is_wr_q, is_wr_d;
   logic          aw_done_q, aw_done_d;
   logic          w_done_q, w_done_d;
   logic          err_q, err_d;
   logic [LW-1:0] rdata_q, rdata_d;

   logic          load_en, store_en, adv_en;
   logic [LW-1:0] load_data, line_data;
   logic [CW-1:0] cnt;
   logic [7:0]    cnt_ext;
   logic [63:0]   beat_sel;

   axi_beat_buf #(.LINE_BEATS(LINE_BEATS)) u_buf (
      .clk        (aclk),
      .rst        (areset),
      .load_en    (load_en),
      .load_data  (load_data),
      .store_en   (store_en),
      .store_data (rdata),
      .adv_en     (adv_en),
      .cnt        (cnt),
      .beat_sel   (beat_sel),
      .line_data  (line_data)
   );

   assign cnt_ext = 8'(cnt);

   // Next-state, handshake outputs and transaction bookkeeping
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      wstrb_d   = wstrb_q;
      is_wr_d   = is_wr_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      req_ready = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      wlast     = 1'b0;
      bready    = 1'b0;
      resp_valid = 1'b0;
      load_en   = 1'b0;
      load_data = req_wdata;
      store_en  = 1'b0;
      adv_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               is_wr_d   = req_write;
               addr_d    = req_single ? req_addr : (req_addr & LINE_MASK);
               len_d     = req_single ? 8'd0 : LINE_LEN;
               size_d    = req_single ? req_size : SIZE_64;
               wstrb_d   = req_single ? req_wstrb : 8'hFF;
               err_d     = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               load_en   = 1'b1;
               // A read starts from the last read line so short bursts keep old beats
               load_data = req_write ? req_wdata : rdata_q;
               state_d   = req_write ? ST_WR : ST_AR;
            end
         end
         ST_AR: begin
            arvalid = 1'b1;
            if (arready) state_d = ST_R;
         end
         ST_R: begin
            rready = 1'b1;
            if (rvalid) begin
               store_en = 1'b1;
               if ((rresp != RESP_OKAY) || (rid != RD_ID)) err_d = 1'b1;
               if (rlast) begin
                  // cnt still counts the beats before this one
                  if (cnt_ext != len_q) err_d = 1'b1;
                  state_d = ST_RESP;
               end
            end
         end
         ST_WR: begin
            awvalid = !aw_done_q;
            wvalid  = !w_done_q;
            wlast   = wvalid && (cnt_ext == len_q);
            if (awvalid && awready) aw_done_d = 1'b1;
            if (wvalid && wready) begin
               adv_en = 1'b1;
               if (wlast) w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) state_d = ST_B;
         end
         ST_B: begin
            bready = 1'b1;
            if (bvalid) begin
               if ((bresp != RESP_OKAY) || (bid != WR_ID)) err_d = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (!is_wr_q) rdata_d = line_data;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and transaction registers
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         wstrb_q   <= '0;
         is_wr_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         wstrb_q   <= wstrb_d;
         is_wr_q   <= is_wr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   // The completing read line is visible during the response pulse itself
   assign resp_rdata = (state_q == ST_RESP && !is_wr_q) ? line_data : rdata_q;
   assign resp_err   = err_q;

   assign araddr  = addr_q;
   assign arid    = RD_ID;
   assign arlen   = len_q;
   assign arsize  = size_q;
   assign arburst = BURST_INCR;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

   assign awid    = WR_ID;
   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awsize  = size_q;
   assign awburst = BURST_INCR;
   assign awlock  = 2'b00;
   assign awcache = 4'b0000;
   assign awprot  = 3'b000;

   assign wid     = WR_ID;
   assign wdata   = beat_sel;
   assign wstrb   = wstrb_q;

   assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_line_master.sv
// Bench for axi_line_master: a cycle-driven AXI slave model with configurable
// delays and responses, a reference model of the expected bus fields, W beats
// and read line, and directed plus randomized scenarios.
module tb_axi_line_master;
   import axi_pkg::*;

   localparam int LB = 4;
   localparam int LW = LB * 64;

   logic          aclk, areset;
   logic          req_valid, req_ready, req_write, req_single;
   logic [31:0]   req_addr;
   logic [2:0]    req_size;
   logic [7:0]    req_wstrb;
   logic [LW-1:0] req_wdata;
   logic          resp_valid, resp_err;
   logic [LW-1:0] resp_rdata;
   logic [31:0]   araddr, awaddr;
   logic [3:0]    arid, awid, wid, rid, bid;
   logic [7:0]    arlen, awlen, wstrb;
   logic [2:0]    arsize, awsize, arprot, awprot;
   logic [1:0]    arburst, awburst, arlock, awlock, rresp, bresp;
   logic [3:0]    arcache, awcache;
   logic          arvalid, arready, rlast, rvalid, rready;
   logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [63:0]   rdata, wdata;
   axi_state_e    dbg_state;

   axi_line_master #(.LINE_BEATS(LB)) dut (
      .aclk(aclk), .areset(areset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_single(req_single), .req_size(req_size),
      .req_wstrb(req_wstrb), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // ---------------- slave configuration ----------------
   int          cfg_ar_delay, cfg_aw_delay, cfg_b_delay, cfg_w_pct, cfg_r_pct;
   int          cfg_n_rbeats, cfg_err_beat;
   logic [1:0]  cfg_rresp, cfg_bresp;
   logic [3:0]  cfg_rid, cfg_bid;
   logic [63:0] cfg_rbeat [0:15];

   // ---------------- observations ----------------
   logic [31:0]   o_addr;
   logic [7:0]    o_len;
   logic [2:0]    o_size;
   logic [1:0]    o_burst;
   logic [3:0]    o_id;
   logic [8:0]    o_attr;
   int            o_chg, o_bad, o_aw_cyc, o_wlast_cyc, o_b_cyc, o_bready_first, o_resp_cyc;
   logic [76:0]   o_w_q [$];
   logic          o_done, o_err, o_resp_after, o_ready_after;
   logic [LW-1:0] o_rdata;

   // ---------------- scoreboard / reference model ----------------
   logic [76:0]   exp_q [$];
   logic [LW-1:0] model_rdata;

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [31:0] m_addr(input logic [31:0] a, input bit single);
      return single ? a : (a / (LB * 8)) * (LB * 8);
   endfunction

   function automatic logic [7:0] m_len(input bit single);
      return single ? 8'd0 : 8'(LB - 1);
   endfunction

   function automatic logic [2:0] m_size(input bit single, input logic [2:0] s);
      return single ? s : 3'd3;
   endfunction

   // Expected W beats: beat i of the line (only beat 0 for a single), last on the final one
   task automatic build_w_exp(input bit single, input logic [7:0] strb, input logic [LW-1:0] wd);
      int n;
      n = single ? 1 : LB;
      exp_q.delete();
      for (int i = 0; i < n; i++)
         exp_q.push_back({4'd1, (i == n - 1) ? 1'b1 : 1'b0, single ? strb : 8'hFF, wd[i*64 +: 64]});
   endtask

   // Read outcome: received beats overwrite the line up to its size; error if count,
   // response code or ID is wrong
   function automatic logic m_read_err(input bit single);
      logic e;
      e = (cfg_n_rbeats != (single ? 1 : LB)) || (cfg_rid != 4'd0);
      if (cfg_err_beat >= 0 && cfg_err_beat < cfg_n_rbeats && cfg_rresp != 2'b00) e = 1'b1;
      return e;
   endfunction

   task automatic model_read_update();
      for (int i = 0; i < cfg_n_rbeats && i < LB; i++) model_rdata[i*64 +: 64] = cfg_rbeat[i];
   endtask

   task automatic set_cfg_default();
      cfg_ar_delay = 0; cfg_aw_delay = 0; cfg_b_delay = 0;
      cfg_w_pct = 100; cfg_r_pct = 100;
      cfg_n_rbeats = LB; cfg_err_beat = -1;
      cfg_rresp = 2'b00; cfg_bresp = 2'b00;
      cfg_rid = 4'd0; cfg_bid = 4'd1;
      for (int i = 0; i < 16; i++) cfg_rbeat[i] = {$urandom, $urandom};
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_single = 1'b0;
      req_size = '0; req_wstrb = '0; req_wdata = '0;
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0; rid = '0; rdata = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
   endtask

   // ---------------- driver: one request plus the slave side, cycle by cycle ----------------
   task automatic run_txn(input bit wr, input logic [31:0] addr, input bit single,
                          input logic [2:0] size, input logic [7:0] strb, input logic [LW-1:0] wd);
      int ar_wait, aw_wait, b_wait, ridx;
      bit req_acc, ar_hs, ar_seen, aw_seen;
      ar_wait = 0; aw_wait = 0; b_wait = 0; ridx = 0;
      req_acc = 0; ar_hs = 0; ar_seen = 0; aw_seen = 0;
      o_w_q.delete();
      o_done = 0; o_err = 0; o_rdata = '0; o_chg = 0; o_bad = 0;
      o_aw_cyc = -1; o_wlast_cyc = -1; o_b_cyc = -1; o_bready_first = -1; o_resp_cyc = -1;
      for (int c = 0; c < 400 && !o_done; c++) begin
         @(negedge aclk);
         cyc++;
         arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'd0; rdata = {$urandom, $urandom};
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
         if (resp_valid) begin
            o_done = 1; o_err = resp_err; o_rdata = resp_rdata; o_resp_cyc = cyc;
         end
         if (wr ? (arvalid || rready) : (awvalid || wvalid || bready)) o_bad++;
         if (!req_acc) begin
            req_valid = 1'b1; req_write = wr; req_addr = addr; req_single = single;
            req_size = size; req_wstrb = strb; req_wdata = wd;
            if (req_ready) req_acc = 1;
         end else begin
            req_valid = 1'b0; req_write = 1'($urandom_range(1)); req_addr = $urandom;
            req_single = 1'($urandom_range(1)); req_size = 3'($urandom_range(7));
            req_wstrb = 8'($urandom); req_wdata = rand_line();
         end
         if (arvalid) begin
            if (!ar_seen) begin
               ar_seen = 1; o_addr = araddr; o_len = arlen; o_size = arsize;
               o_burst = arburst; o_id = arid; o_attr = {arlock, arcache, arprot};
            end else if ({araddr, arlen, arsize} != {o_addr, o_len, o_size}) o_chg++;
            if (ar_wait >= cfg_ar_delay) begin arready = 1'b1; ar_hs = 1; end
            else ar_wait++;
         end
         if (ar_hs && rready && ridx < cfg_n_rbeats && $urandom_range(99) < cfg_r_pct) begin
            rvalid = 1'b1; rdata = cfg_rbeat[ridx]; rlast = (ridx == cfg_n_rbeats - 1);
            rresp = (ridx == cfg_err_beat) ? cfg_rresp : 2'b00; rid = cfg_rid;
            ridx++;
         end
         if (awvalid) begin
            if (!aw_seen) begin
               aw_seen = 1; o_addr = awaddr; o_len = awlen; o_size = awsize;
               o_burst = awburst; o_id = awid; o_attr = {awlock, awcache, awprot};
            end else if ({awaddr, awlen, awsize} != {o_addr, o_len, o_size}) o_chg++;
            if (aw_wait >= cfg_aw_delay) begin awready = 1'b1; o_aw_cyc = cyc; end
            else aw_wait++;
         end
         if (wvalid && $urandom_range(99) < cfg_w_pct) begin
            wready = 1'b1;
            o_w_q.push_back({wid, wlast, wstrb, wdata});
            if (wlast) o_wlast_cyc = cyc;
         end
         if (bready) begin
            if (o_bready_first < 0) o_bready_first = cyc;
            if (b_wait >= cfg_b_delay) begin
               bvalid = 1'b1; bresp = cfg_bresp; bid = cfg_bid; o_b_cyc = cyc;
            end else b_wait++;
         end
      end
      @(negedge aclk);
      cyc++;
      o_resp_after = resp_valid;
      o_ready_after = req_ready;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      areset = 1'b1;
      repeat (2) @(negedge aclk);
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      n_tests++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin n_fail++;
         $display("FAIL reset_valids: got %b want 00000", {arvalid, rready, awvalid, wvalid, bready}); end
      n_tests++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin n_fail++;
         $display("FAIL reset_resp: got valid=%b err=%b want 0 0", resp_valid, resp_err); end
      n_tests++; if (resp_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
      n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
      areset = 1'b0;
      model_rdata = '0;
      @(negedge aclk);
   endtask

   task automatic test_line_read();
      set_cfg_default();
      for (int i = 0; i < LB; i++) cfg_rbeat[i] = 64'(i + 1);
      run_txn(1'b0, 32'h8000_0014, 1'b0, 3'd0, 8'h00, '0);
      model_read_update();
      n_tests++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL line_read_done: got %b want 1 (timeout)", o_done); end
      n_tests++; if (o_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL line_read_araddr: got %h want 80000000", o_addr); end
      n_tests++; if ({o_len, o_size} !== {8'd3, 3'd3}) begin n_fail++;
         $display("FAIL line_read_len_size: got len=%0d size=%0d want 3 3", o_len, o_size); end
      n_tests++; if ({o_burst, o_id, o_attr} !== {2'b01, 4'd0, 9'd0}) begin n_fail++;
         $display("FAIL line_read_attr: got burst=%b id=%0d attr=%h want 01 0 0", o_burst, o_id, o_attr); end
      n_tests++; if (o_rdata !== {64'd4, 64'd3, 64'd2, 64'd1}) begin n_fail++;
         $display("FAIL line_read_data: got %h want beats 1,2,3,4", o_rdata); end
      n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL line_read_err: got %b want 0", o_err); end
      n_tests++; if (o_resp_after !== 1'b0 || o_ready_after !== 1'b1) begin n_fail++;
         $display("FAIL line_read_pulse: after resp valid=%b ready=%b want 0 1", o_resp_after, o_ready_after); end
   endtask

   task automatic test_single_write();
      logic [LW-1:0] wd;
      set_cfg_default();
      cfg_b_delay = 2;
      wd = rand_line();
      build_w_exp(1'b1, 8'h0F, wd);
      run_txn(1'b1, 32'h8000_0008, 1'b1, 3'd2, 8'h0F, wd);
      n_tests++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL single_write_done: got %b want 1 (timeout)", o_done); end
      n_tests++; if ({o_addr, o_len, o_size} !== {32'h8000_0008, 8'd0, 3'd2}) begin n_fail++;
         $display("FAIL single_write_aw: got addr=%h len=%0d size=%0d want 80000008 0 2", o_addr, o_len, o_size); end
      n_tests++; if (o_id !== 4'd1) begin n_fail++; $display("FAIL single_write_awid: got %0d want 1", o_id); end
      n_tests++; if (o_w_q.size() != 1 || o_w_q[0] !== exp_q[0]) begin n_fail++;
         $display("FAIL single_write_wbeat: got %0d beats first=%h want 1 beat %h", o_w_q.size(), o_w_q.size() > 0 ? o_w_q[0] : 77'd0, exp_q[0]); end
      n_tests++; if (o_resp_cyc != o_b_cyc + 1) begin n_fail++;
         $display("FAIL single_write_resp_latency: got resp cycle %0d want %0d", o_resp_cyc, o_b_cyc + 1); end
      n_tests++; if (o_err !== 1'b0 || o_rdata !== model_rdata) begin n_fail++;
         $display("FAIL single_write_resp: got err=%b rdata=%h want 0 %h", o_err, o_rdata, model_rdata); end
   endtask

   task automatic test_write_aw_delay();
      logic [LW-1:0] wd;
      set_cfg_default();
      cfg_aw_delay = 5;
      wd = rand_line();
      build_w_exp(1'b0, 8'h00, wd);
      run_txn(1'b1, 32'h1234_5678, 1'b0, 3'd0, 8'h00, wd);
      n_tests++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL aw_delay_done: got %b want 1 (timeout)", o_done); end
      n_tests++; if (o_addr !== 32'h1234_5660 || o_len !== 8'd3) begin n_fail++;
         $display("FAIL aw_delay_aw: got addr=%h len=%0d want 12345660 3", o_addr, o_len); end
      n_tests++; if (o_w_q.size() != exp_q.size()) begin n_fail++;
         $display("FAIL aw_delay_wcount: got %0d want %0d", o_w_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
         n_tests++; if (o_w_q[i] !== exp_q[i]) begin n_fail++;
            $display("FAIL aw_delay_wbeat%0d: got %h want %h", i, o_w_q[i], exp_q[i]); end
      end
      n_tests++; if (!(o_wlast_cyc >= 0 && o_wlast_cyc < o_aw_cyc)) begin n_fail++;
         $display("FAIL aw_delay_order: got wlast cycle %0d aw cycle %0d want wlast first", o_wlast_cyc, o_aw_cyc); end
      n_tests++; if (o_bready_first != o_aw_cyc + 1) begin n_fail++;
         $display("FAIL aw_delay_b_entry: got bready at %0d want %0d", o_bready_first, o_aw_cyc + 1); end
   endtask

   task automatic test_short_read();
      logic [63:0] prior3;
      set_cfg_default();
      cfg_n_rbeats = 3;
      prior3 = model_rdata[3*64 +: 64];
      run_txn(1'b0, 32'h0000_0100, 1'b0, 3'd0, 8'h00, '0);
      model_read_update();
      n_tests++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL short_read_done: got %b want 1 (timeout)", o_done); end
      n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL short_read_err: got %b want 1", o_err); end
      n_tests++; if (o_rdata[3*64 +: 64] !== prior3) begin n_fail++;
         $display("FAIL short_read_beat3: got %h want %h", o_rdata[3*64 +: 64], prior3); end
      n_tests++; if (o_rdata !== model_rdata) begin n_fail++;
         $display("FAIL short_read_data: got %h want %h", o_rdata, model_rdata); end
   endtask

   task automatic test_bresp_err();
      set_cfg_default();
      cfg_bresp = 2'b10;
      run_txn(1'b1, 32'h4000_0040, 1'b0, 3'd0, 8'h00, rand_line());
      n_tests++; if (o_done !== 1'b1 || o_err !== 1'b1) begin n_fail++;
         $display("FAIL bresp_err: got done=%b err=%b want 1 1", o_done, o_err); end
      set_cfg_default();
      cfg_n_rbeats = 1;
      run_txn(1'b0, 32'h4000_0044, 1'b1, 3'd2, 8'h00, '0);
      model_read_update();
      n_tests++; if (o_done !== 1'b1 || o_err !== 1'b0) begin n_fail++;
         $display("FAIL bresp_next_clean: got done=%b err=%b want 1 0", o_done, o_err); end
      n_tests++; if (o_rdata !== model_rdata) begin n_fail++;
         $display("FAIL bresp_next_data: got %h want %h", o_rdata, model_rdata); end
   endtask

   task automatic test_reset_mid_read();
      int pulses;
      set_cfg_default();
      idle_inputs();
      @(negedge aclk);
      req_valid = 1'b1; req_write = 1'b0; req_single = 1'b0; req_addr = 32'h0000_2000;
      @(negedge aclk);
      req_valid = 1'b0;
      n_tests++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL mid_reset_arvalid_latency: got %b want 1", arvalid); end
      arready = 1'b1;
      @(negedge aclk);
      arready = 1'b0;
      n_tests++; if (rready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_rready: got %b want 1", rready); end
      rvalid = 1'b1; rdata = cfg_rbeat[0]; rid = 4'd0; rlast = 1'b0;
      @(negedge aclk);
      rvalid = 1'b1; rdata = cfg_rbeat[1];
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0; rvalid = 1'b0;
      n_tests++; if ({arvalid, rready, resp_valid} !== 3'b000) begin n_fail++;
         $display("FAIL mid_reset_outputs: got arvalid=%b rready=%b resp_valid=%b want 0 0 0", arvalid, rready, resp_valid); end
      n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL mid_reset_state: got %0d want IDLE", dbg_state); end
      pulses = 0;
      repeat (4) begin @(negedge aclk); if (resp_valid) pulses++; end
      n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL mid_reset_no_resp: got %0d pulses want 0", pulses); end
      model_rdata = '0;
      set_cfg_default();
      run_txn(1'b0, 32'h0000_2008, 1'b0, 3'd0, 8'h00, '0);
      model_read_update();
      n_tests++; if (o_done !== 1'b1 || o_err !== 1'b0 || o_rdata !== model_rdata) begin n_fail++;
         $display("FAIL mid_reset_next_read: got done=%b err=%b data=%h want 1 0 %h", o_done, o_err, o_rdata, model_rdata); end
   endtask

   task automatic test_random();
      bit wr, single;
      logic [31:0] addr;
      logic [2:0] size;
      logic [7:0] strb;
      logic [LW-1:0] wd;
      logic exp_err;
      for (int t = 0; t < 40; t++) begin
         set_cfg_default();
         wr = 1'($urandom_range(1));
         single = ($urandom_range(3) == 0);
         addr = $urandom; size = 3'($urandom_range(3)); strb = 8'($urandom); wd = rand_line();
         cfg_ar_delay = $urandom_range(3); cfg_aw_delay = $urandom_range(4); cfg_b_delay = $urandom_range(3);
         cfg_w_pct = $urandom_range(100, 40); cfg_r_pct = $urandom_range(100, 40);
         cfg_n_rbeats = single ? 1 : LB;
         if ($urandom_range(5) == 0) cfg_n_rbeats = $urandom_range(LB + 1, 1);
         if ($urandom_range(4) == 0) begin cfg_err_beat = $urandom_range(LB - 1); cfg_rresp = 2'($urandom_range(3, 1)); end
         if ($urandom_range(7) == 0) cfg_rid = 4'($urandom_range(15, 1));
         if ($urandom_range(7) == 0) cfg_bid = 4'd9;
         if ($urandom_range(5) == 0) cfg_bresp = 2'($urandom_range(3, 1));
         if (wr) build_w_exp(single, strb, wd);
         run_txn(wr, addr, single, size, strb, wd);
         n_tests++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_done: got %b want 1 (timeout)", t, o_done); end
         n_tests++; if ({o_addr, o_len, o_size, o_burst, o_attr} !== {m_addr(addr, single), m_len(single), m_size(single, size), 2'b01, 9'd0}) begin
            n_fail++;
            $display("FAIL rnd%0d_addr_fields: got addr=%h len=%0d size=%0d burst=%b attr=%h want addr=%h len=%0d size=%0d",
                     t, o_addr, o_len, o_size, o_burst, o_attr, m_addr(addr, single), m_len(single), m_size(single, size)); end
         n_tests++; if (o_id !== (wr ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL rnd%0d_id: got %0d want %0d", t, o_id, wr ? 1 : 0); end
         n_tests++; if (o_chg != 0 || o_bad != 0) begin n_fail++;
            $display("FAIL rnd%0d_protocol: got %0d addr changes %0d wrong-channel cycles want 0 0", t, o_chg, o_bad); end
         if (wr) begin
            exp_err = (cfg_bresp != 2'b00) || (cfg_bid != 4'd1);
            n_tests++; if (o_w_q.size() != exp_q.size()) begin n_fail++;
               $display("FAIL rnd%0d_wcount: got %0d want %0d", t, o_w_q.size(), exp_q.size()); end
            else for (int i = 0; i < exp_q.size(); i++) begin
               n_tests++; if (o_w_q[i] !== exp_q[i]) begin n_fail++;
                  $display("FAIL rnd%0d_wbeat%0d: got %h want %h", t, i, o_w_q[i], exp_q[i]); end
            end
         end else begin
            exp_err = m_read_err(single);
            model_read_update();
         end
         n_tests++; if (o_err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b", t, o_err, exp_err); end
         n_tests++; if (o_rdata !== model_rdata) begin n_fail++;
            $display("FAIL rnd%0d_rdata: got %h want %h", t, o_rdata, model_rdata); end
         n_tests++; if (o_resp_after !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_pulse: got %b want 0", t, o_resp_after); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_line_read();
      test_single_write();
      test_write_aw_delay();
      test_short_read();
      test_bresp_err();
      test_reset_mid_read();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_line_master.md
AXI_LINE_MASTER -- requirements
Module: axi_line_master

Interface
REQ-001 SHALL have parameter LINE_BEATS, default 4, meaning 64-bit beats per cache line (power of two, 2..16).
REQ-002 SHALL have parameters RD_ID, default 4'd0, and WR_ID, default 4'd1, giving the arid and awid values.
REQ-003 aclk  in  1  sole clock; all logic on rising edge.
REQ-004 areset  in  1  synchronous, active-high reset.
REQ-005 req_valid/req_ready  in/out  1/1  request handshake.
REQ-006 req_write  in  1  1=write, 0=read.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_single  in  1  1=single beat, 0=line burst.
REQ-009 req_size  in  3  AXI size for single-beat requests.
REQ-010 req_wstrb  in  8  byte strobe for single-beat writes.
REQ-011 req_wdata  in  LINE_BEATS*64  write data; beat i is bits [64i+63:64i].
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_err  out  1  error flag, qualified by resp_valid.
REQ-014 resp_rdata  out  LINE_BEATS*64  read data, same beat layout as req_wdata.
REQ-015 AR channel outputs: araddr 32, arid 4, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1; input arready 1.
REQ-016 R channel inputs: rid 4, rdata 64, rresp 2, rlast 1, rvalid 1; output rready 1.
REQ-017 AW channel outputs: awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awlock 2, awcache 4, awprot 3, awvalid 1; input awready 1.
REQ-018 W channel outputs: wid 4, wdata 64, wstrb 8, wlast 1, wvalid 1; input wready 1.
REQ-019 B channel inputs: bid 4, bresp 2, bvalid 1; output bready 1.

Function
REQ-020 SHALL implement an FSM with states IDLE, AR, R, WR, B, RESP and SHALL allow one outstanding transaction.
REQ-021 req_ready SHALL be 1 only in IDLE; a request SHALL be captured on the edge where req_valid && req_ready.
REQ-022 On a read capture the FSM SHALL go to AR, driving arvalid=1 in the next cycle (1-cycle latency).
REQ-023 Line requests SHALL set address = req_addr with the low log2(LINE_BEATS*8) bits cleared, len = LINE_BEATS-1, size = 3.
REQ-024 Single-beat requests SHALL set address = req_addr, len = 0, size = req_size.
REQ-025 Burst SHALL be INCR (2'b01); lock, cache and prot SHALL be 0.
REQ-026 Read address fields SHALL remain stable while arvalid=1 and arready=0; on the AR handshake the FSM SHALL go to R.
REQ-027 In R, rready SHALL be 1; each R handshake SHALL store rdata into beat[cnt] and increment the beat counter; beats with cnt >= LINE_BEATS SHALL be discarded.
REQ-028 The R handshake with rlast=1 SHALL move the FSM to RESP.
REQ-029 On a write capture the FSM SHALL go to WR, asserting awvalid and wvalid together next cycle.
REQ-030 awvalid SHALL drop after the AW handshake, independent of W progress.
REQ-031 In WR, wdata SHALL be beat[cnt]; each W handshake SHALL advance cnt; wlast SHALL be 1 on beat len; wid SHALL equal WR_ID.
REQ-032 wstrb SHALL be 8'hFF for line writes and req_wstrb for single-beat writes.
REQ-033 The FSM SHALL leave WR for B only when both the AW handshake and the last W handshake have occurred, in either order or the same cycle.
REQ-034 In B, bready SHALL be 1; the B handshake SHALL move the FSM to RESP.
REQ-035 RESP SHALL last exactly one cycle with resp_valid=1, then the FSM SHALL return to IDLE.
REQ-036 resp_rdata SHALL hold its value until the next read completes.
REQ-037 resp_err SHALL be the sticky OR, over the transaction, of: any rresp/bresp != 0; rlast with beat count != len+1; rid != RD_ID; or bid != WR_ID.

Reset
REQ-038 While areset=1: the FSM SHALL go to IDLE; all valid/ready outputs SHALL be 0 (except req_ready, which SHALL be 1 after reset); beat counter, resp_err and resp_rdata SHALL be 0.
REQ-039 Reset mid-transaction SHALL abandon the transaction without issuing resp_valid.

Structure
REQ-040 A shared package axi_pkg SHALL hold the BURST_INCR and RESP_OKAY/SLVERR/DECERR constants, the default ID values, and the FSM state enum.
REQ-041 The beat buffer (capture, beat select, counter) SHALL be a single sub-module named axi_beat_buf.

Verification
REQ-042 Line read at 0x8000_0014 with a 0-wait slave returning 1,2,3,4 -> araddr=0x8000_0000, arlen=3, arsize=3; resp_rdata beats = 1,2,3,4; resp_err=0.
REQ-043 Single write at 0x8000_0008, req_size=2, req_wstrb=8'h0F -> awlen=0, one W beat with wlast=1, wstrb=8'h0F; resp_valid one cycle after the B handshake.
REQ-044 Line write with awready delayed 5 cycles and wready=1 -> all 4 W beats complete first; the FSM enters B only after the AW handshake.
REQ-045 Line read with rlast asserted on the 3rd beat -> completes with resp_err=1; beat 3 retains its prior value.
REQ-046 Write with bresp=2'b10 -> resp_err=1; the next request completes with resp_err=0.
REQ-047 areset asserted during R beat 2 -> next cycle arvalid=rready=0, FSM in IDLE, no resp_valid; a subsequent read completes normally.
